// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_rx control front-end.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [1:0] W5 = 2'b00;
  localparam logic [1:0] W6 = 2'b01;
  localparam logic [1:0] W7 = 2'b10;
  localparam logic [1:0] W8 = 2'b11;

  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // Mask keeping only the bits of the active frame width.
  function automatic logic [DATA_W-1:0] data_mask(input logic [1:0] code);
    logic [DATA_W-1:0] m;
    case (code)
      W5:      m = 8'h1F;
      W6:      m = 8'h3F;
      W7:      m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Valid/ready read port of the RX FIFO; the controller is the master side.
interface uart_rx_rd_if;
  import uart_pkg::*;

  logic              o_rd_valid;
  logic              i_rd_ready;
  logic [DATA_W-1:0] o_rd_data;
  logic              o_rd_perr;

  modport master (output o_rd_valid, output o_rd_data, output o_rd_perr, input i_rd_ready);
  modport slave  (input o_rd_valid, input o_rd_data, input o_rd_perr, output i_rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO of received entries; a push into a full FIFO is only taken with a same-cycle pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  rx_entry_t              din,
  input  logic                   pop,
  output rx_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rx_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx front-end: tick generator, frame-activity FSM, deferred config commit and RX capture FIFO.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV   = 325,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned TIMEOUT_TICKS = 208
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_wr,
  input  logic [15:0]                 cfg_divisor,
  input  logic [1:0]                  cfg_num_bit_data,
  input  logic                        cfg_parity_en,
  input  logic                        cfg_parity_type,
  output logic                        o_cfg_pending,
  output logic                        o_rx_tick,
  output logic [1:0]                  o_num_bit_data,
  output logic                        o_parity_en,
  output logic                        o_parity_type,
  input  logic                        i_rx_serial,
  input  logic [DATA_W-1:0]           i_rx_data,
  input  logic                        i_rx_done,
  input  logic                        i_parity_err,
  uart_rx_rd_if.master                rd,
  output logic                        o_overrun,
  input  logic                        i_overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [15:0]   divisor, tick_cnt;
  logic [TW-1:0] to_cnt;
  logic          s1, s2, s3, done_d;
  logic          start_edge, done_rise, commit;
  logic [15:0]   sh_divisor;
  logic [1:0]    sh_num_bit_data;
  logic          sh_parity_en, sh_parity_type;
  logic          fifo_full, fifo_empty, pop;
  rx_entry_t     push_entry, head;

  assign start_edge = s3 & ~s2;
  assign done_rise  = i_rx_done & ~done_d;
  assign commit     = o_cfg_pending & (state_q == IDLE) & ~start_edge;

  // Line synchroniser and done edge detector; the line idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      done_d <= 1'b0;
    end else begin
      s1     <= i_rx_serial;
      s2     <= s1;
      s3     <= s2;
      done_d <= i_rx_done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Timeout releases BUSY after glitches that never produce a done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = BUSY;
      BUSY:    if (done_rise || to_cnt >= TW'(TIMEOUT_TICKS)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              to_cnt <= '0;
    else if (state_q == IDLE && start_edge)  to_cnt <= '0;
    else if (state_q == BUSY && o_rx_tick)   to_cnt <= to_cnt + TW'(1);
  end

  // Oversampling tick; restarts whenever a new divisor takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      o_rx_tick <= 1'b0;
    end else if (commit) begin
      tick_cnt  <= '0;
      o_rx_tick <= 1'b0;
    end else if (tick_cnt >= divisor) begin
      tick_cnt  <= '0;
      o_rx_tick <= 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + 16'(1);
      o_rx_tick <= 1'b0;
    end
  end

  // Shadow config is applied only between frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_divisor      <= 16'(DEFAULT_DIV);
      sh_num_bit_data <= W8;
      sh_parity_en    <= 1'b0;
      sh_parity_type  <= 1'b0;
      o_cfg_pending   <= 1'b0;
      divisor         <= 16'(DEFAULT_DIV);
      o_num_bit_data  <= W8;
      o_parity_en     <= 1'b0;
      o_parity_type   <= 1'b0;
    end else begin
      if (commit) begin
        divisor        <= sh_divisor;
        o_num_bit_data <= sh_num_bit_data;
        o_parity_en    <= sh_parity_en;
        o_parity_type  <= sh_parity_type;
      end
      if (cfg_wr) begin
        sh_divisor      <= cfg_divisor;
        sh_num_bit_data <= cfg_num_bit_data;
        sh_parity_en    <= cfg_parity_en;
        sh_parity_type  <= cfg_parity_type;
      end
      o_cfg_pending <= cfg_wr | (o_cfg_pending & ~commit);
    end
  end

  assign push_entry = '{perr: i_parity_err, data: i_rx_data & data_mask(o_num_bit_data)};
  assign pop        = rd.o_rd_valid & rd.i_rd_ready;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (done_rise),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_fifo_count)
  );

  assign rd.o_rd_valid = ~fifo_empty;
  assign rd.o_rd_data  = head.data;
  assign rd.o_rd_perr  = head.perr;

  // Set wins over clear when a drop coincides with the clear strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             o_overrun <= 1'b0;
    else if (done_rise && fifo_full && !pop) o_overrun <= 1'b1;
    else if (i_overrun_clr)                 o_overrun <= 1'b0;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control and buffering front-end for the uart_rx receiver datapath.
- Generates the 16x-oversampling rx_tick from a programmable divisor.
- Owns the active frame configuration (width and parity) and applies host updates only between frames.
- Captures each received byte plus its parity-error flag into a small show-ahead FIFO with a valid/ready read port and a sticky overrun flag.

Parameters:
DEFAULT_DIV, 325, reset divisor; tick period is DEFAULT_DIV+1 clocks (50 MHz / 9600 baud x16).
FIFO_DEPTH, 4, entries in the RX FIFO; power of 2, minimum 2.
TIMEOUT_TICKS, 208, ticks after a start edge before BUSY self-clears (13 bit-times x16).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_wr  in  1  one-cycle strobe; loads the cfg_* values into the shadow registers
cfg_divisor  in  16  new tick divisor
cfg_num_bit_data  in  2  new width code: 00=5, 01=6, 10=7, 11=8 bits
cfg_parity_en  in  1  new parity enable
cfg_parity_type  in  1  new parity type: 0=even, 1=odd
o_cfg_pending  out  1  shadow configuration written but not yet committed
o_rx_tick  out  1  one-cycle tick pulse to uart_rx
o_num_bit_data  out  2  active width code to uart_rx
o_parity_en  out  1  active parity enable to uart_rx
o_parity_type  out  1  active parity type to uart_rx
i_rx_serial  in  1  serial line, monitored for frame activity
i_rx_data  in  8  uart_rx o_data
i_rx_done  in  1  uart_rx o_rx_done; may stay high for several cycles
i_parity_err  in  1  uart_rx o_parity_err
o_rd_valid  out  1  FIFO non-empty
i_rd_ready  in  1  consumer accepts the head entry
o_rd_data  out  8  head byte; bits above the active width read as 0
o_rd_perr  out  1  head entry parity-error flag
o_overrun  out  1  sticky: a byte was dropped because the FIFO was full
i_overrun_clr  in  1  clears o_overrun
o_fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, all state):
  - divisor = DEFAULT_DIV; o_num_bit_data = 2'b11; o_parity_en = 0; o_parity_type = 0.
  - o_rx_tick = 0; o_cfg_pending = 0; state = IDLE.
  - FIFO empty: o_rd_valid = 0, o_fifo_count = 0, o_rd_data = 0, o_rd_perr = 0; o_overrun = 0.
- Tick generator:
  - 16-bit counter; when counter >= divisor, counter <= 0 and o_rx_tick <= 1; otherwise counter increments and o_rx_tick <= 0.
  - Period is divisor+1 clocks. Divisor 0 gives a tick every cycle.
  - A divisor commit zeroes the counter.
- Line monitor: i_rx_serial passes through a 2-FF synchroniser. A start edge is synced high in the previous cycle and synced low now.
- Activity FSM, IDLE/BUSY:
  - IDLE -> BUSY on a start edge; the tick counter for the timeout is zeroed.
  - BUSY -> IDLE on the rising edge of i_rx_done, or when the timeout count reaches TIMEOUT_TICKS. The timeout covers glitches, which produce no done.
  - Start edges are ignored while BUSY.
- Config:
  - cfg_wr loads the shadow registers and sets pending. A cfg_wr while pending overwrites the shadow.
  - Commit happens on the first edge where pending && state==IDLE && no start edge this cycle. At commit all four active fields update together and pending clears.
  - Latency: cfg_wr sampled while idle gives new outputs 2 clocks later.
  - cfg_wr in the same cycle as a commit: the new values go to the shadow and pending stays set.
- Capture:
  - Push occurs on the rising edge of i_rx_done (edge-detected, so one push per frame).
  - The entry is {i_parity_err, i_rx_data masked to the active width}.
- FIFO:
  - Show-ahead; a pop occurs when o_rd_valid && i_rd_ready.
  - Push when full: the byte is dropped and o_overrun is set, except when a pop happens in the same cycle, in which case the push is accepted.
  - Push when empty with simultaneous i_rd_ready: no bypass; the entry becomes visible the next cycle.
  - Overrun set and i_overrun_clr in the same cycle: set wins.
  - Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package uart_pkg:
  - width-code localparams W5/W6/W7/W8;
  - DATA_W = 8;
  - packed struct rx_entry_t {perr, data[7:0]};
  - a function returning the data mask for a width code.
- Sub-module uart_rx_fifo: synchronous show-ahead FIFO of rx_entry_t with push/pop/full/empty/count.
- Tick generator, synchroniser and FSM stay in uart_rx_ctrl.

Test Plan:
- Reset, divisor 325 -> o_rx_tick pulses exactly every 326 clocks; width code 11, parity off.
- Instantiate with uart_rx, send 8N1 0x55 then 0xAA back-to-back -> FIFO count 2; pops return 0x55 then 0xAA with perr=0.
- cfg_wr (width 00, parity even) mid-frame -> pending=1 until that frame's done, then outputs switch. Send 5-bit 0x1F -> o_rd_data 0x1F.
- Send 8E1 0x03 with inverted parity -> entry 0x03, perr=1.
- Hold i_rd_ready=0 and send 5 frames -> count 4, o_overrun=1, head still the first byte. Then assert i_overrun_clr -> o_overrun=0.
- Quarter-bit low glitch -> BUSY, no push, return to IDLE after 208 ticks; a pending config commits afterwards.
